dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock shared with pc, register, status and data_memory.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 cpu_req / dbg_req  input  1 each  port requests one access in the next grant cycle.
REQ-005 cpu_we / dbg_we  input  1 each  access is a write (1) or a read (0).
REQ-006 cpu_addr / dbg_addr  input  8 each  access address.
REQ-007 cpu_wdata / dbg_wdata  input  8 each  write data.
REQ-008 cpu_lock / dbg_lock  input  1 each  hold ownership for the next access (read-modify-write).
REQ-009 cpu_gnt / dbg_gnt  output  1 each  registered; access is performed in this cycle.
REQ-010 cpu_rvalid / dbg_rvalid  output  1 each  registered; read data valid in this cycle.
REQ-011 cpu_rdata / dbg_rdata  output  8 each  registered read data.
REQ-012 mem_addr, mem_data_in  output  8 each; mem_W  output  1; mem_data_out  input  8  connect to data_memory address, data_in, W and data_out.

Function
REQ-013 FSM states: IDLE, CPU, DBG; the state register drives the grants (CPU -> cpu_gnt=1, DBG -> dbg_gnt=1, never both).
REQ-014 Next state is evaluated at each rising edge from current req, lock, state and the last_owner flag.
REQ-015 Priority at each edge:
  - current owner requesting with its lock=1 -> same owner;
  - otherwise only one requester -> that port;
  - both requesting -> the port not equal to last_owner (round-robin);
  - none -> IDLE.
REQ-016 A request asserted in cycle T SHALL be granted no earlier than T+1; worst-case latency without lock is 2 cycles.
REQ-017 In a grant cycle, mem_addr, mem_data_in and mem_W SHALL be taken combinationally from the granted port's addr, wdata and we; in IDLE mem_W=0, mem_addr=0 and mem_data_in=0.
REQ-018 A write SHALL commit at the rising edge that ends the grant cycle.
REQ-019 A read SHALL capture mem_data_out into the owner's rdata at the end of the grant cycle and assert that port's rvalid for exactly the following cycle; rdata holds its value until the next read for that port.
REQ-020 Each grant cycle is exactly one access; a port wanting N accesses keeps req high until it has seen N grants, and req may depend combinationally on gnt.
REQ-021 last_owner SHALL update to the granted port on every grant and hold through IDLE.
REQ-022 Lock SHALL be ignored when its port does not own the current cycle; a locked port dropping req releases ownership.
REQ-023 Requesters SHALL hold addr, we and wdata stable while req=1; the arbiter does not register them.

Reset
REQ-024 While reset is asserted:
  - state=IDLE, last_owner=DBG (so CPU wins the first tie);
  - cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid = 0;
  - cpu_rdata, dbg_rdata = 0.
REQ-025 Reset asserted during a grant cycle SHALL immediately force mem_W=0, so no write commits, and drop any pending rvalid.
REQ-026 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Structure
REQ-027 The state encoding (IDLE/CPU/DBG) and port ids (PORT_CPU=0, PORT_DBG=1) SHALL live in a shared package also used by the computer top.
REQ-028 One sub-module is natural: rr_pick (two-input round-robin selector with lock override); the rest is inline.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
  - Reset: reset pulse mid-grant with cpu_we=1, addr=8'h10, wdata=8'hAA -> mem[0x10] unchanged, all gnt/rvalid = 0.
  - Single CPU write then read: write 8'h5C at addr 8'h20, then read it -> cpu_gnt one cycle each; cpu_rvalid one cycle after the read grant with cpu_rdata=8'h5C.
  - Contention: both req held high for 4 grants after reset -> grant order CPU, DBG, CPU, DBG.
  - Lock: dbg_lock=1 with both requesting -> DBG granted for consecutive cycles until dbg_lock drops; the CPU is granted on the next cycle.
  - Back-to-back reads: dbg reads addr 1 then addr 2 on consecutive grants -> dbg_rvalid high 2 consecutive cycles with data in order.
  - Idle: no requests -> mem_W=0 and state stays IDLE indefinitely.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared arbiter state encoding and port ids for the data-memory arbiter and computer top.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCpu  = 2'd1,
      StDbg  = 2'd2
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   function automatic arb_state_e port_state(input logic port);
      return (port == PORT_CPU) ? StCpu : StDbg;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-input round-robin selector; a locked, still-requesting owner keeps the next slot.
module dmem_arbiter_rr_pick
   import dmem_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       dbg_req,
   input  logic       cpu_lock,
   input  logic       dbg_lock,
   input  arb_state_e state,
   input  logic       last_owner,
   output arb_state_e next
);

   always_comb begin
      next = StIdle;
      if (state == StCpu && cpu_req && cpu_lock) begin
         next = StCpu;
      end else if (state == StDbg && dbg_req && dbg_lock) begin
         next = StDbg;
      end else if (cpu_req && dbg_req) begin
         // Tie goes to whoever did not own the most recent grant.
         next = port_state(~last_owner);
      end else if (cpu_req) begin
         next = StCpu;
      end else if (dbg_req) begin
         next = StDbg;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug ports onto the single-ported data memory, one access per grant cycle.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   input  logic       cpu_lock,
   input  logic       dbg_req,
   input  logic       dbg_we,
   input  logic [7:0] dbg_addr,
   input  logic [7:0] dbg_wdata,
   input  logic       dbg_lock,
   output logic       cpu_gnt,
   output logic       dbg_gnt,
   output logic       cpu_rvalid,
   output logic       dbg_rvalid,
   output logic [7:0] cpu_rdata,
   output logic [7:0] dbg_rdata,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data_in,
   output logic       mem_W,
   input  logic [7:0] mem_data_out
);

   arb_state_e state_q;
   arb_state_e pick;
   logic       last_owner_q;
   logic       ready_q;

   dmem_arbiter_rr_pick u_rr_pick (
      .cpu_req    (cpu_req),
      .dbg_req    (dbg_req),
      .cpu_lock   (cpu_lock),
      .dbg_lock   (dbg_lock),
      .state      (state_q),
      .last_owner (last_owner_q),
      .next       (pick)
   );

   // ready_q swallows the first edge after reset release so no grant appears before the second.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         last_owner_q <= PORT_DBG;
         ready_q      <= 1'b0;
         cpu_rvalid   <= 1'b0;
         dbg_rvalid   <= 1'b0;
         cpu_rdata    <= 8'h00;
         dbg_rdata    <= 8'h00;
      end else begin
         ready_q    <= 1'b1;
         cpu_rvalid <= (state_q == StCpu) && !cpu_we;
         dbg_rvalid <= (state_q == StDbg) && !dbg_we;
         if (state_q == StCpu && !cpu_we) cpu_rdata <= mem_data_out;
         if (state_q == StDbg && !dbg_we) dbg_rdata <= mem_data_out;
         if (ready_q) begin
            state_q <= pick;
            if (pick == StCpu) last_owner_q <= PORT_CPU;
            else if (pick == StDbg) last_owner_q <= PORT_DBG;
         end
      end
   end

   assign cpu_gnt = (state_q == StCpu);
   assign dbg_gnt = (state_q == StDbg);

   always_comb begin
      mem_addr    = 8'h00;
      mem_data_in = 8'h00;
      mem_W       = 1'b0;
      unique case (state_q)
         StCpu: begin
            mem_addr    = cpu_addr;
            mem_data_in = cpu_wdata;
            mem_W       = cpu_we & ~reset;
         end
         StDbg: begin
            mem_addr    = dbg_addr;
            mem_data_in = dbg_wdata;
            mem_W       = dbg_we & ~reset;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a reset-abort sequence followed by a per-cycle vector table.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, cpu_lock, dbg_req, dbg_we, dbg_lock;
   logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic       cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_W;
   logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_data_in, mem_data_out;
   logic       mem_init;
   logic [7:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_lock     (cpu_lock),
      .dbg_req      (dbg_req),
      .dbg_we       (dbg_we),
      .dbg_addr     (dbg_addr),
      .dbg_wdata    (dbg_wdata),
      .dbg_lock     (dbg_lock),
      .cpu_gnt      (cpu_gnt),
      .dbg_gnt      (dbg_gnt),
      .cpu_rvalid   (cpu_rvalid),
      .dbg_rvalid   (dbg_rvalid),
      .cpu_rdata    (cpu_rdata),
      .dbg_rdata    (dbg_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_W        (mem_W),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural data_memory: combinational read, write at the edge ending the grant cycle.
   assign mem_data_out = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h01] <= 8'h11;
         mem[8'h02] <= 8'h22;
         mem[8'h03] <= 8'h44;
         mem[8'h10] <= 8'h33;
      end else if (mem_W) begin
         mem[mem_addr] <= mem_data_in;
      end
   end

   typedef struct {
      logic       rst;
      logic [2:0] c;     // {req, we, lock}
      logic [7:0] ca, cw;
      logic [2:0] d;
      logic [7:0] da, dw;
      logic [3:0] g;     // {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid}
      logic [7:0] crd, drd;
      logic       mw;
      logic [7:0] ma, md;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [2:0] c, input logic [7:0] ca, cw,
                      input logic [2:0] d, input logic [7:0] da, dw, input logic [3:0] g,
                      input logic [7:0] crd, drd, input logic mw, input logic [7:0] ma, md);
      vec_t v;
      v.rst = rst; v.c = c; v.ca = ca; v.cw = cw; v.d = d; v.da = da; v.dw = dw;
      v.g = g; v.crd = crd; v.drd = drd; v.mw = mw; v.ma = ma; v.md = md;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic found;
      reset = 1'b1; mem_init = 1'b1;
      {cpu_req, cpu_we, cpu_lock, dbg_req, dbg_we, dbg_lock} = '0;
      {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      check("reset_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_W, cpu_rdata, dbg_rdata},
            '0);

      // Reset abort mid-write; request is raised right at release to probe the start-up delay.
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hAA;
      @(posedge clk); #1;
      check("no_gnt_first_edge", cpu_gnt, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(posedge clk); #1;
         if (cpu_gnt) found = 1'b1;
      end
      check("rst_write_gnt", found, 1'b1);
      check("rst_write_memw", {mem_W, mem_addr, mem_data_in}, {1'b1, 8'h10, 8'hAA});
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_abort_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_W}, '0);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      @(posedge clk); #1;
      check("rst_mem_unchanged", mem[8'h10], 8'h33);
      @(negedge clk);
      reset = 1'b0;

      // CPU write 5C @20 then read it back
      add(0, 3'b110, 8'h20, 8'h5C, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b010, 8'h20, 8'h5C, 3'b000, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 1, 8'h20, 8'h5C);
      add(0, 3'b100, 8'h20, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b000, 8'h20, 8'h00, 3'b000, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 0, 8'h20, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0010, 8'h5C, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h5C, 8'h00, 0, 8'h00, 8'h00);
      // Contention right after reset: CPU, DBG, CPU, DBG
      add(1, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b1000, 8'h00, 8'h00, 0, 8'h02, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0110, 8'h22, 8'h00, 0, 8'h01, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h01, 8'h00, 4'b1001, 8'h22, 8'h11, 0, 8'h02, 8'h00);
      add(0, 3'b000, 8'h02, 8'h00, 3'b000, 8'h01, 8'h00, 4'b0110, 8'h22, 8'h11, 0, 8'h01, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0001, 8'h22, 8'h11, 0, 8'h00, 8'h00);
      // DBG back-to-back reads of addr 1 then 2
      add(0, 3'b000, 8'h00, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0000, 8'h22, 8'h11, 0, 8'h00, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b100, 8'h01, 8'h00, 4'b0100, 8'h22, 8'h11, 0, 8'h01, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h02, 8'h00, 4'b0101, 8'h22, 8'h11, 0, 8'h02, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0001, 8'h22, 8'h22, 0, 8'h00, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0000, 8'h22, 8'h22, 0, 8'h00, 8'h00);
      // DBG lock holds ownership against a waiting CPU
      add(0, 3'b000, 8'h00, 8'h00, 3'b101, 8'h03, 8'h00, 4'b0000, 8'h22, 8'h22, 0, 8'h00, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b101, 8'h03, 8'h00, 4'b0100, 8'h22, 8'h22, 0, 8'h03, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b101, 8'h03, 8'h00, 4'b0101, 8'h22, 8'h44, 0, 8'h03, 8'h00);
      add(0, 3'b100, 8'h02, 8'h00, 3'b100, 8'h03, 8'h00, 4'b0101, 8'h22, 8'h44, 0, 8'h03, 8'h00);
      add(0, 3'b000, 8'h02, 8'h00, 3'b100, 8'h03, 8'h00, 4'b1001, 8'h22, 8'h44, 0, 8'h02, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h03, 8'h00, 4'b0110, 8'h22, 8'h44, 0, 8'h03, 8'h00);
      add(0, 3'b000, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 4'b0001, 8'h22, 8'h44, 0, 8'h00, 8'h00);
      // Idle: we/addr wiggling without req must never reach memory
      for (int i = 0; i < 4; i++)
         add(0, 3'b010, 8'h55, 8'h77, 3'b010, 8'h66, 8'h88, 4'b0000, 8'h22, 8'h44, 0, 8'h00, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         reset = vecs[i].rst;
         {cpu_req, cpu_we, cpu_lock} = vecs[i].c;
         cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cw;
         {dbg_req, dbg_we, dbg_lock} = vecs[i].d;
         dbg_addr = vecs[i].da; dbg_wdata = vecs[i].dw;
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, mem_W, mem_addr,
                mem_data_in},
               {vecs[i].g, vecs[i].crd, vecs[i].drd, vecs[i].mw, vecs[i].ma, vecs[i].md});
      end
      check("mem_20_written", mem[8'h20], 8'h5C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
